// File: rtl/obj_table_unit.sv
// rtl/obj_table_unit.sv - object ID to dense video_mem slot mapper
// Keeps live objects packed in slots 0..cnt-1; deletes refill the hole from the last slot.
module obj_table_unit #(
  parameter int NUM_OBJ = 32,
  parameter int ID_W    = $clog2(NUM_OBJ),
  parameter int ADDR_W  = $clog2(NUM_OBJ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_vld,
  output logic               o_cmd_rdy,
  input  logic [1:0]         i_cmd_op,
  input  logic [ID_W-1:0]    i_cmd_obj,
  input  logic               i_hold,
  output logic               o_rsp_vld,
  output logic               o_rsp_ok,
  output logic [ID_W-1:0]    o_rsp_obj,
  output logic [ADDR_W-1:0]  o_rsp_addr,
  output logic               o_mv_req,
  output logic [ADDR_W-1:0]  o_mv_src,
  output logic [ADDR_W-1:0]  o_mv_dst,
  input  logic               i_mv_done,
  output logic [NUM_OBJ-1:0] o_obj_map,
  output logic [ID_W:0]      o_obj_cnt,
  output logic               o_full,
  output logic               o_empty,
  output logic [ID_W-1:0]    o_lst_obj,
  output logic               o_lst_obj_vld
);

  localparam logic [1:0] OP_CRT     = 2'b00;
  localparam logic [1:0] OP_DEL     = 2'b01;
  localparam logic [1:0] OP_DEL_ALL = 2'b10;
  localparam logic [1:0] OP_LOOKUP  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_CLR, S_RESP} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_id2slot [NUM_OBJ];
  logic [ID_W-1:0]     r_slot2id [NUM_OBJ];
  logic [NUM_OBJ-1:0]  r_id_vld;
  logic [ID_W:0]       r_cnt;
  logic [ID_W-1:0]     r_del_obj;
  logic [ADDR_W-1:0]   r_clr_idx;
  logic                r_rsp_vld;
  logic                r_rsp_ok;
  logic [ID_W-1:0]     r_rsp_obj;
  logic [ADDR_W-1:0]   r_rsp_addr;
  logic                r_mv_req;
  logic [ADDR_W-1:0]   r_mv_src;
  logic [ADDR_W-1:0]   r_mv_dst;

  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_last_slot;
  logic [ADDR_W-1:0]   w_new_slot;
  logic [ID_W-1:0]     w_free_id;
  logic [ADDR_W-1:0]   w_obj_slot;
  logic                w_obj_vld;
  logic [ID_W-1:0]     w_moved_id;
  logic [NUM_OBJ-1:0]  w_obj_map;

  assign w_full      = (r_cnt == (ID_W+1)'(NUM_OBJ));
  assign w_empty     = (r_cnt == '0);
  assign w_last_slot = ADDR_W'(r_cnt - 1'b1);
  assign w_new_slot  = r_cnt[ADDR_W-1:0];
  assign o_cmd_rdy   = (r_state == S_IDLE) && !i_hold;
  assign w_accept    = i_cmd_vld && o_cmd_rdy;
  assign w_obj_slot  = r_id2slot[i_cmd_obj];
  assign w_obj_vld   = r_id_vld[i_cmd_obj];
  assign w_moved_id  = r_slot2id[r_mv_src];

  // Lowest unused ID wins; a free ID always exists whenever the table is not full.
  always_comb begin
    w_free_id = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (!r_id_vld[i]) w_free_id = ID_W'(i);
    end
  end

  always_comb begin
    w_obj_map = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      w_obj_map[i] = ((ID_W+1)'(i) < r_cnt);
    end
  end

  assign o_obj_map     = w_obj_map;
  assign o_obj_cnt     = r_cnt;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_lst_obj_vld = !w_empty;
  assign o_lst_obj     = w_empty ? '0 : r_slot2id[w_last_slot];
  assign o_rsp_vld     = r_rsp_vld;
  assign o_rsp_ok      = r_rsp_ok;
  assign o_rsp_obj     = r_rsp_obj;
  assign o_rsp_addr    = r_rsp_addr;
  assign o_mv_req      = r_mv_req;
  assign o_mv_src      = r_mv_src;
  assign o_mv_dst      = r_mv_dst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_id_vld   <= '0;
      r_cnt      <= '0;
      r_del_obj  <= '0;
      r_clr_idx  <= '0;
      r_rsp_vld  <= 1'b0;
      r_rsp_ok   <= 1'b0;
      r_rsp_obj  <= '0;
      r_rsp_addr <= '0;
      r_mv_req   <= 1'b0;
      r_mv_src   <= '0;
      r_mv_dst   <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        r_id2slot[i] <= '0;
        r_slot2id[i] <= '0;
      end
    end else begin
      r_rsp_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (i_cmd_op)
              OP_CRT: begin
                r_rsp_vld <= 1'b1;
                if (!w_full) begin
                  r_id_vld[w_free_id]   <= 1'b1;
                  r_id2slot[w_free_id]  <= w_new_slot;
                  r_slot2id[w_new_slot] <= w_free_id;
                  r_cnt                 <= r_cnt + 1'b1;
                  r_rsp_ok              <= 1'b1;
                  r_rsp_obj             <= w_free_id;
                  r_rsp_addr            <= w_new_slot;
                end else begin
                  r_rsp_ok   <= 1'b0;
                  r_rsp_obj  <= '0;
                  r_rsp_addr <= '0;
                end
              end
              OP_DEL: begin
                r_rsp_obj  <= i_cmd_obj;
                r_rsp_addr <= '0;
                if (!w_obj_vld) begin
                  r_rsp_vld <= 1'b1;
                  r_rsp_ok  <= 1'b0;
                end else if (w_obj_slot == w_last_slot) begin
                  r_id_vld[i_cmd_obj] <= 1'b0;
                  r_cnt               <= r_cnt - 1'b1;
                  r_rsp_vld           <= 1'b1;
                  r_rsp_ok            <= 1'b1;
                end else begin
                  // Hole in the middle: ask video_mem to copy the last slot into it.
                  r_mv_req  <= 1'b1;
                  r_mv_src  <= w_last_slot;
                  r_mv_dst  <= w_obj_slot;
                  r_del_obj <= i_cmd_obj;
                  r_state   <= S_MOVE;
                end
              end
              OP_DEL_ALL: begin
                r_cnt     <= '0;
                r_clr_idx <= '0;
                r_state   <= S_CLR;
              end
              OP_LOOKUP: begin
                r_rsp_vld  <= 1'b1;
                r_rsp_ok   <= w_obj_vld;
                r_rsp_obj  <= i_cmd_obj;
                r_rsp_addr <= w_obj_vld ? w_obj_slot : '0;
              end
              default: ;
            endcase
          end
        end
        S_MOVE: begin
          if (i_mv_done) begin
            r_id2slot[w_moved_id] <= r_mv_dst;
            r_slot2id[r_mv_dst]   <= w_moved_id;
            r_id_vld[r_del_obj]   <= 1'b0;
            r_cnt                 <= r_cnt - 1'b1;
            r_mv_req              <= 1'b0;
            r_rsp_vld             <= 1'b1;
            r_rsp_ok              <= 1'b1;
            r_rsp_obj             <= r_del_obj;
            r_rsp_addr            <= '0;
            r_state               <= S_RESP;
          end
        end
        S_CLR: begin
          r_id_vld[r_clr_idx]  <= 1'b0;
          r_id2slot[r_clr_idx] <= '0;
          r_slot2id[r_clr_idx] <= '0;
          if (r_clr_idx == ADDR_W'(NUM_OBJ - 1)) begin
            r_rsp_vld  <= 1'b1;
            r_rsp_ok   <= 1'b1;
            r_rsp_obj  <= '0;
            r_rsp_addr <= '0;
            r_state    <= S_RESP;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obj_table_unit.sv
// tb/tb_obj_table_unit.sv - randomized self-checking bench for obj_table_unit
// The model keeps live IDs as a queue in slot order; every negedge compares DUT state to it.
module tb_obj_table_unit;
  localparam int N  = 32;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_cmd_vld = 1'b0;
  logic          o_cmd_rdy;
  logic [1:0]    i_cmd_op = 2'b00;
  logic [IW-1:0] i_cmd_obj = '0;
  logic          i_hold = 1'b0;
  logic          o_rsp_vld, o_rsp_ok;
  logic [IW-1:0] o_rsp_obj, o_rsp_addr;
  logic          o_mv_req;
  logic [IW-1:0] o_mv_src, o_mv_dst;
  logic          i_mv_done = 1'b0;
  logic [N-1:0]  o_obj_map;
  logic [IW:0]   o_obj_cnt;
  logic          o_full, o_empty, o_lst_obj_vld;
  logic [IW-1:0] o_lst_obj;

  always #5 clk = ~clk;

  obj_table_unit #(.NUM_OBJ(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy),
    .i_cmd_op(i_cmd_op), .i_cmd_obj(i_cmd_obj), .i_hold(i_hold),
    .o_rsp_vld(o_rsp_vld), .o_rsp_ok(o_rsp_ok), .o_rsp_obj(o_rsp_obj), .o_rsp_addr(o_rsp_addr),
    .o_mv_req(o_mv_req), .o_mv_src(o_mv_src), .o_mv_dst(o_mv_dst), .i_mv_done(i_mv_done),
    .o_obj_map(o_obj_map), .o_obj_cnt(o_obj_cnt), .o_full(o_full), .o_empty(o_empty),
    .o_lst_obj(o_lst_obj), .o_lst_obj_vld(o_lst_obj_vld)
  );

  int checks = 0;
  int failures = 0;

  int slots[$];
  bit m_busy = 0;
  bit cmp_en = 0;
  bit exp_rsp = 0, exp_ok = 0, exp_chk_obj = 0, exp_chk_addr = 0;
  int exp_obj = 0, exp_addr = 0;
  bit exp_mv = 0;
  int exp_src = 0, exp_dst = 0;
  int last_rsp_ok = 0, last_rsp_obj = 0, last_rsp_addr = 0;
  int last_mv_src = -1, last_mv_dst = -1, mv_cycles = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int find_slot(input int id);
    foreach (slots[i]) if (slots[i] == id) return i;
    return -1;
  endfunction

  function automatic int lowest_free();
    for (int id = 0; id < N; id++) if (find_slot(id) < 0) return id;
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    int c;
    logic [63:0] m;
    if (cmp_en) begin
      c = slots.size();
      m = (c == N) ? {N{1'b1}} : ((64'd1 << c) - 64'd1);
      chk("obj_cnt", o_obj_cnt, c);
      chk("obj_map", o_obj_map, m);
      chk("full", o_full, c == N);
      chk("empty", o_empty, c == 0);
      chk("lst_obj_vld", o_lst_obj_vld, c != 0);
      if (c != 0) chk("lst_obj", o_lst_obj, slots[c-1]);
      chk("cmd_rdy", o_cmd_rdy, !m_busy && !i_hold);
      chk("rsp_vld", o_rsp_vld, exp_rsp);
      if (exp_rsp && o_rsp_vld) begin
        chk("rsp_ok", o_rsp_ok, exp_ok);
        if (exp_chk_obj) chk("rsp_obj", o_rsp_obj, exp_obj);
        if (exp_chk_addr) chk("rsp_addr", o_rsp_addr, exp_addr);
      end
      chk("mv_req", o_mv_req, exp_mv);
      if (exp_mv) begin
        chk("mv_src", o_mv_src, exp_src);
        chk("mv_dst", o_mv_dst, exp_dst);
      end
      if (o_rsp_vld) begin
        last_rsp_ok = o_rsp_ok; last_rsp_obj = o_rsp_obj; last_rsp_addr = o_rsp_addr;
      end
      if (o_mv_req) begin
        mv_cycles++; last_mv_src = o_mv_src; last_mv_dst = o_mv_dst;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rsp(input bit ok, input bit cobj, input int obj, input bit caddr, input int addr);
    exp_rsp = 1; exp_ok = ok; exp_chk_obj = cobj; exp_obj = obj; exp_chk_addr = caddr; exp_addr = addr;
  endtask

  // Issue one command from IDLE and walk the model through its full latency.
  task automatic do_cmd(input int op, input int obj, input int mv_wait, input bit rnd_hold);
    int idx, id;
    i_hold = 0;
    i_cmd_vld = 1; i_cmd_op = 2'(op); i_cmd_obj = IW'(obj);
    tick();
    i_cmd_vld = 0;
    case (op)
      0: begin
        if (slots.size() < N) begin
          id = lowest_free(); slots.push_back(id);
          set_rsp(1, 1, id, 1, slots.size() - 1);
        end else set_rsp(0, 0, 0, 0, 0);
        tick(); exp_rsp = 0;
      end
      1: begin
        idx = find_slot(obj);
        if (idx < 0) begin
          set_rsp(0, 1, obj, 0, 0); tick(); exp_rsp = 0;
        end else if (idx == slots.size() - 1) begin
          void'(slots.pop_back()); set_rsp(1, 1, obj, 0, 0); tick(); exp_rsp = 0;
        end else begin
          m_busy = 1; exp_mv = 1; exp_src = slots.size() - 1; exp_dst = idx;
          for (int k = 0; k < mv_wait; k++) begin
            if (rnd_hold) i_hold = ($urandom_range(0, 2) == 0);
            tick();
          end
          i_mv_done = 1;
          tick();
          i_mv_done = 0; exp_mv = 0;
          slots[idx] = slots[slots.size() - 1]; void'(slots.pop_back());
          set_rsp(1, 1, obj, 0, 0);
          tick();
          exp_rsp = 0; m_busy = 0; i_hold = 0;
        end
      end
      2: begin
        m_busy = 1; slots.delete();
        for (int k = 0; k < N; k++) begin
          if (rnd_hold) i_hold = ($urandom_range(0, 2) == 0);
          tick();
        end
        set_rsp(1, 0, 0, 0, 0);
        tick();
        exp_rsp = 0; m_busy = 0; i_hold = 0;
      end
      default: begin
        idx = find_slot(obj);
        set_rsp(idx >= 0, 1, obj, 1, (idx >= 0) ? idx : 0);
        tick(); exp_rsp = 0;
      end
    endcase
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, obj, mvc;
    tick();
    chk("rst_cnt", o_obj_cnt, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_rdy", o_cmd_rdy, 1);
    chk("rst_rsp", o_rsp_vld, 0);
    chk("rst_mv", o_mv_req, 0);
    chk("rst_map", o_obj_map, 0);
    tick();
    rst = 0;
    cmp_en = 1;
    tick();

    for (int i = 0; i < 3; i++) begin
      do_cmd(0, 0, 0, 0);
      chk("s1_obj", last_rsp_obj, i);
      chk("s1_addr", last_rsp_addr, i);
    end
    chk("s1_map", o_obj_map, 32'h7);
    chk("s1_lst", o_lst_obj, 2);

    do_cmd(1, 0, 3, 0);
    chk("s2_src", last_mv_src, 2);
    chk("s2_dst", last_mv_dst, 0);
    do_cmd(3, 2, 0, 0);
    chk("s2_addr", last_rsp_addr, 0);
    chk("s2_cnt", o_obj_cnt, 2);
    chk("s2_lst", o_lst_obj, 1);

    do_cmd(0, 0, 0, 0);
    chk("s3_obj", last_rsp_obj, 0);
    chk("s3_addr", last_rsp_addr, 2);
    mvc = mv_cycles;
    do_cmd(1, 0, 0, 0);
    chk("s3_nomv", mv_cycles, mvc);
    chk("s3_ok", last_rsp_ok, 1);

    while (slots.size() < N) do_cmd(0, 0, 0, 0);
    chk("s4_full", o_full, 1);
    do_cmd(0, 0, 0, 0);
    chk("s4_ok", last_rsp_ok, 0);
    chk("s4_cnt", o_obj_cnt, N);
    do_cmd(1, 5, 1, 0);
    do_cmd(3, 5, 0, 0);
    chk("s4_lookup", last_rsp_ok, 0);
    do_cmd(0, 0, 0, 0);
    chk("s4_refill", last_rsp_obj, 5);

    do_cmd(2, 0, 0, 0);
    chk("s5_empty", o_empty, 1);
    chk("s5_map", o_obj_map, 0);

    i_hold = 1; i_cmd_vld = 1; i_cmd_op = 2'b00;
    repeat (4) tick();
    i_cmd_vld = 0; i_hold = 0;
    chk("s6_hold_cnt", o_obj_cnt, 0);
    tick();

    // Random phase; stray mv_done pulses in IDLE must be ignored.
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (slots.size() != 0 && $urandom_range(0, 2) != 0)
        obj = slots[$urandom_range(0, slots.size() - 1)];
      else
        obj = $urandom_range(0, N - 1);
      if (r < 42)      do_cmd(0, 0, 0, 0);
      else if (r < 75) do_cmd(1, obj, $urandom_range(0, 4), 1);
      else if (r < 96) do_cmd(3, obj, 0, 0);
      else             do_cmd(2, 0, 0, 1);
      if ($urandom_range(0, 9) == 0) begin
        i_mv_done = 1; tick(); i_mv_done = 0;
      end
    end

    while (slots.size() < 4) do_cmd(0, 0, 0, 0);
    i_cmd_vld = 1; i_cmd_op = 2'b01; i_cmd_obj = IW'(slots[0]);
    tick();
    i_cmd_vld = 0; m_busy = 1; exp_mv = 1; exp_src = slots.size() - 1; exp_dst = 0;
    tick();
    #2;
    rst = 1;
    #1;
    chk("s6_rst_mv", o_mv_req, 0);
    chk("s6_rst_cnt", o_obj_cnt, 0);
    slots.delete(); exp_mv = 0; m_busy = 0;
    tick();
    rst = 0;
    tick();
    do_cmd(0, 0, 0, 0);
    chk("s6_post_obj", last_rsp_obj, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
